// File: rtl/jpeg_bitstream_unstuffer_if.sv
//------------------------------------------------------------------------------
// jpeg_bitstream_unstuffer_if : byte stream, bit window and marker bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface jpeg_bitstream_unstuffer_if #(
    parameter int BUF_W  = 32,
    parameter int FILL_W = $clog2(BUF_W + 1)
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       peek_bits;
    logic [FILL_W-1:0] bits_avail;
    logic              consume_valid;
    logic [4:0]        consume_len;
    logic              marker_valid;
    logic [7:0]        marker_code;
    logic              marker_ack;
    logic              err_underflow;
    logic              err_clr;
`ifdef JPEG_UNSTUFF_STATS_EN
    logic [15:0]       stuff_cnt;
`endif

    modport slave (
`ifdef JPEG_UNSTUFF_STATS_EN
        output stuff_cnt,
`endif
        input  in_data, in_valid, consume_valid, consume_len, marker_ack, err_clr,
        output in_ready, peek_bits, bits_avail, marker_valid, marker_code, err_underflow
    );

    modport master (
`ifdef JPEG_UNSTUFF_STATS_EN
        input  stuff_cnt,
`endif
        output in_data, in_valid, consume_valid, consume_len, marker_ack, err_clr,
        input  in_ready, peek_bits, bits_avail, marker_valid, marker_code, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/jpeg_bitstream_unstuffer.sv
//------------------------------------------------------------------------------
// jpeg_bitstream_unstuffer : removes 0xFF00 stuffing, skips fill bytes, stops
// on markers and exposes a left-aligned bit window. Optional: JPEG_UNSTUFF_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jpeg_bitstream_unstuffer #(
    parameter int BUF_W  = 32,
    parameter int FILL_W = $clog2(BUF_W + 1)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    jpeg_bitstream_unstuffer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SAW_FF = 2'd1,
        ST_MARKER = 2'd2
    } state_t;

    localparam logic [FILL_W-1:0] C_APPEND_MAX = FILL_W'(BUF_W - 8);

    state_t            state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        marker_code_q, marker_code_d;
    logic              err_q, err_d;

    logic              marker_clear;
    logic              len_ok;
    logic              consume_take;
    logic              consume_bad;
    logic [FILL_W-1:0] eff_len;
    logic [FILL_W-1:0] fill_after;
    logic [BUF_W-1:0]  buf_after;
    logic              in_ready;
    logic              accept;
    logic              app_en;
    logic [7:0]        app_byte;
    logic              stuff_hit;

    always_comb begin
        marker_clear = (state_q == ST_MARKER) && bus.marker_ack;
        len_ok       = bus.consume_valid && (bus.consume_len != 5'd0) &&
                       (bus.consume_len <= 5'd16) &&
                       (FILL_W'(bus.consume_len) <= fill_q);
        // A marker release discards the buffer, so a same-cycle consume is moot.
        consume_take = len_ok && !marker_clear;
        consume_bad  = bus.consume_valid && !len_ok && !marker_clear;
        eff_len      = consume_take ? FILL_W'(bus.consume_len) : '0;
        fill_after   = fill_q - eff_len;
        buf_after    = buf_q << eff_len;
        in_ready     = rst_n && (state_q != ST_MARKER) && (fill_after <= C_APPEND_MAX);
        accept       = bus.in_valid && in_ready;

        state_d       = state_q;
        buf_d         = buf_after;
        fill_d        = fill_after;
        marker_code_d = marker_code_q;
        err_d         = (err_q && !bus.err_clr) || consume_bad;
        app_en        = 1'b0;
        app_byte      = bus.in_data;
        stuff_hit     = 1'b0;

        if (accept) begin
            case (state_q)
                ST_NORMAL: begin
                    if (bus.in_data == 8'hFF) state_d = ST_SAW_FF;
                    else                      app_en  = 1'b1;
                end
                ST_SAW_FF: begin
                    if (bus.in_data == 8'h00) begin
                        app_en    = 1'b1;
                        app_byte  = 8'hFF;
                        stuff_hit = 1'b1;
                        state_d   = ST_NORMAL;
                    end else if (bus.in_data != 8'hFF) begin
                        state_d       = ST_MARKER;
                        marker_code_d = bus.in_data;
                    end
                end
                default: ;
            endcase
        end

        if (app_en) begin
            buf_d  = buf_after | ({{(BUF_W-8){1'b0}}, app_byte} << (C_APPEND_MAX - fill_after));
            fill_d = fill_after + FILL_W'(8);
        end

        if (marker_clear) begin
            buf_d   = '0;
            fill_d  = '0;
            state_d = ST_NORMAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            buf_q         <= '0;
            fill_q        <= '0;
            marker_code_q <= 8'h00;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            fill_q        <= fill_d;
            marker_code_q <= marker_code_d;
            err_q         <= err_d;
        end
    end

`ifdef JPEG_UNSTUFF_STATS_EN
    logic [15:0] stuff_cnt_q, stuff_cnt_d;

    always_comb begin
        stuff_cnt_d = stuff_cnt_q;
        if (marker_clear)                           stuff_cnt_d = 16'h0000;
        else if (stuff_hit && stuff_cnt_q != 16'hFFFF) stuff_cnt_d = stuff_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stuff_cnt_q <= 16'h0000;
        else        stuff_cnt_q <= stuff_cnt_d;
    end

    assign bus.stuff_cnt = stuff_cnt_q;
`else
    logic unused_stuff;
    assign unused_stuff = stuff_hit;
`endif

    assign bus.in_ready      = in_ready;
    assign bus.peek_bits     = buf_q[BUF_W-1 -: 16];
    assign bus.bits_avail    = fill_q;
    assign bus.marker_valid  = (state_q == ST_MARKER);
    assign bus.marker_code   = marker_code_q;
    assign bus.err_underflow = err_q;

endmodule

`default_nettype wire
